vga_fb_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA display path and a host writer.

---
 rtl/vga_fb_arbiter_pkg.sv | 27 ++
 rtl/vga_fb_arbiter_if.sv | 27 ++
 rtl/vga_fb_arbiter_fifo.sv | 56 +++++
 rtl/vga_fb_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and defaults for the VGA framebuffer arbiter.
//  - arb_state_e : arbiter FSM states
//  - gnt_e       : per-cycle RAM grant selection
//  - sat_inc16   : saturating 16-bit increment used by the optional statistics counters
package vga_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 19;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PIXELS_DEF = 307200;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    FLUSH,
    RUN
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_HOST
  } gnt_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer RAM bus between the arbiter and a single-port synchronous RAM.
//  master : arbiter side (drives address/strobes/write data, receives read data)
//  slave  : RAM side (read data returned one cycle after mem_re)
interface vga_fb_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// vga_arb_fifo: DEPTH x DATA_W synchronous prefetch FIFO.
//  clock/reset : rising edge, asynchronous active-high reset
//  flush       : clears pointers and count (wins over push/pop)
//  push/wdata  : write one word; the caller guarantees there is room
//  pop         : advance head when non-empty
//  head        : current head word (combinational)
//  count/empty : occupancy
module vga_arb_fifo #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_pop;

  assign do_pop = pop && (count_q != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the display
// prefetch path and a host writer.
//  clock, reset             : rising edge, asynchronous active-high reset
//  frame_start, vid_active  : from the VGA timing generator
//  pixel_data/pixel_valid   : pixel popped from the prefetch FIFO (0 when not valid)
//  underflow                : sticky, visible pixel requested with an empty FIFO
//  wr_req/wr_addr/wr_data   : host write request, held until wr_ack
//  wr_ack                   : pulses in the cycle the host write reaches the RAM
//  mem                      : RAM bus (vga_fb_arbiter_if.master)
// Optional build macro VGA_ARB_STATS_EN adds stat_underruns/stat_writes
// saturating counters, cleared only by reset.
module vga_fb_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOW_WATER = 4,
  parameter int unsigned PIXELS    = PIXELS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              vid_active,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  vga_fb_arbiter_if.master  mem
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]       stat_underruns,
  output logic [15:0]       stat_writes
`endif
);

  localparam int unsigned       CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     LOW_LVL  = CW'(LOW_WATER);
  localparam logic [CW-1:0]     FULL_LVL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(PIXELS);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              inflight_q;
  logic              underflow_q;

  gnt_e              gnt;
  logic [CW-1:0]     fifo_cnt, level;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, fifo_flush, fifo_push, fifo_pop;
  logic              fetch_done, uf_evt;

  // The in-flight read is counted so a granted read always has a free slot.
  assign level      = fifo_cnt + CW'(inflight_q);
  assign fetch_done = (fetch_addr_q == LAST);
  assign fifo_flush = (state_q == FLUSH);
  // Read data returning in a frame_start cycle belongs to the old frame.
  assign fifo_push  = inflight_q && !frame_start && !fifo_flush;
  assign fifo_pop   = vid_active && !fifo_empty && !fifo_flush;
  assign uf_evt     = vid_active && fifo_empty;

  vga_arb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mem.mem_rdata),
    .head  (fifo_head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Display is urgent at or below the low-water mark; otherwise host first,
  // then opportunistic prefetch up to full.
  always_comb begin
    gnt = GNT_NONE;
    if (!frame_start) begin
      case (state_q)
        WAIT_FRAME: if (wr_req) gnt = GNT_HOST;
        RUN: begin
          if ((level <= LOW_LVL) && !fetch_done)      gnt = GNT_DISP;
          else if (wr_req)                            gnt = GNT_HOST;
          else if ((level < FULL_LVL) && !fetch_done) gnt = GNT_DISP;
        end
        default: gnt = GNT_NONE;
      endcase
    end
  end

  assign mem.mem_re    = (gnt == GNT_DISP);
  assign mem.mem_we    = (gnt == GNT_HOST);
  assign mem.mem_addr  = (gnt == GNT_DISP) ? fetch_addr_q :
                         (gnt == GNT_HOST) ? wr_addr      : '0;
  assign mem.mem_wdata = (gnt == GNT_HOST) ? wr_data : '0;
  assign wr_ack        = (gnt == GNT_HOST);

  assign pixel_data  = fifo_pop ? fifo_head : '0;
  assign pixel_valid = fifo_pop;
  assign underflow   = underflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      fetch_addr_q <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      inflight_q <= (gnt == GNT_DISP);
      if (gnt == GNT_DISP) fetch_addr_q <= fetch_addr_q + 1'b1;

      if (frame_start || (state_q == FLUSH)) underflow_q <= 1'b0;
      else if (uf_evt)                       underflow_q <= 1'b1;

      case (state_q)
        WAIT_FRAME: if (frame_start) state_q <= FLUSH;
        FLUSH: begin
          fetch_addr_q <= '0;
          state_q      <= frame_start ? FLUSH : RUN;
        end
        RUN:        if (frame_start) state_q <= FLUSH;
        default:    state_q <= WAIT_FRAME;
      endcase
    end
  end

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stat_underruns_q, stat_writes_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_underruns_q <= '0;
      stat_writes_q    <= '0;
    end else begin
      stat_underruns_q <= sat_inc16(stat_underruns_q, uf_evt);
      stat_writes_q    <= sat_inc16(stat_writes_q, gnt == GNT_HOST);
    end
  end

  assign stat_underruns = stat_underruns_q;
  assign stat_writes    = stat_writes_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: random video/host traffic, a RAM model whose
// frame content is a fixed function of address, and a reference model that
// tracks reads issued and pixels consumed per frame.
module tb_vga_fb_arbiter;
  import vga_arb_pkg::*;

  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 16;
  localparam int          LOW   = 4;
  localparam int          PIX   = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start, vid_active, wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, pixel_data;
  logic          pixel_valid, underflow;
`ifdef VGA_ARB_STATS_EN
  logic [15:0]   stat_underruns, stat_writes;
`endif

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_fb_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .LOW_WATER (LOW),
    .PIXELS    (PIX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .vid_active  (vid_active),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .underflow   (underflow),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .mem         (bus)
`ifdef VGA_ARB_STATS_EN
    ,
    .stat_underruns (stat_underruns),
    .stat_writes    (stat_writes)
`endif
  );

  always #5 clock = ~clock;

  // Frame content seen by the display path.
  function automatic logic [DW-1:0] pat(input int unsigned a);
    return DW'(a * 37 + 11);
  endfunction

  // RAM model: read data one cycle after mem_re, garbage otherwise.
  always @(posedge clock)
    bus.mem_rdata <= bus.mem_re ? pat(32'(bus.mem_addr)) : DW'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] pix_q[$];
  int unsigned   rd_q[$];

  // Reference model state
  bit m_started, m_uf;
  int m_since, m_issued, m_issued_old, m_popped;
  bit ack_s;

  task automatic model_reset();
    m_started = 0; m_uf = 0; m_since = 0;
    m_issued = 0; m_issued_old = 0; m_popped = 0;
    pix_q.delete(); rd_q.delete();
  endtask

  task automatic step();
    bit fs, va, wr, flush, run, fd, e_re, e_we, e_pop;
    int level, cnt;
    fs = frame_start; va = vid_active; wr = wr_req;
    flush = m_started && (m_since == 1);
    run   = m_started && (m_since >= 2);
    level = m_issued - m_popped;       // words fetched or in flight, not yet shown
    cnt   = m_issued_old - m_popped;   // words already landed in the FIFO
    fd    = (m_issued == PIX);
    e_re = 0; e_we = 0;
    if (!fs) begin
      if (!m_started) e_we = wr;
      else if (run) begin
        if (level <= LOW && !fd)        e_re = 1;
        else if (wr)                    e_we = 1;
        else if (level < DEPTH && !fd)  e_re = 1;
      end
    end
    e_pop = va && (cnt > 0) && !flush;

    chk("mem_re", 32'(bus.mem_re), 32'(e_re));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("wr_ack", 32'(wr_ack), 32'(e_we));
    chk("pixel_valid", 32'(pixel_valid), 32'(e_pop));
    chk("underflow", 32'(underflow), 32'(m_uf));

    if (bus.mem_re) begin
      chk("rd_expected", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) chk("rd_addr", 32'(bus.mem_addr), rd_q.pop_front());
    end
    if (bus.mem_we) begin
      chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(w.a));
        chk("wr_data", 32'(bus.mem_wdata), 32'(w.d));
      end
    end
    if (!bus.mem_re && !bus.mem_we) begin
      chk("idle_addr", 32'(bus.mem_addr), 32'd0);
      chk("idle_wdata", 32'(bus.mem_wdata), 32'd0);
    end
    if (pixel_valid) begin
      chk("pix_expected", 32'(pix_q.size() > 0), 32'd1);
      if (pix_q.size() > 0) chk("pixel_data", 32'(pixel_data), 32'(pix_q.pop_front()));
    end else begin
      chk("pixel_zero", 32'(pixel_data), 32'd0);
    end

    m_issued_old = m_issued;
    if (e_re)  m_issued++;
    if (e_pop) m_popped++;
    if (fs || flush)            m_uf = 0;
    else if (va && cnt == 0)    m_uf = 1;
    if (flush) begin
      m_issued = 0; m_issued_old = 0; m_popped = 0;
      pix_q.delete(); rd_q.delete();
      for (int unsigned i = 0; i < PIX; i++) begin
        rd_q.push_back(i);
        pix_q.push_back(pat(i));
      end
    end
    if (fs) begin
      m_started = 1;
      m_since   = 1;
    end else if (m_started && m_since < 2) begin
      m_since++;
    end
  endtask

  // Monitor: checks every cycle at the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      ack_s = wr_ack;
      if (reset) begin
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel_data", 32'(pixel_data), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_mem_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        model_reset();
      end else begin
        step();
      end
    end
  end

  // Driver
  int hold = 0;
  bit fs_prev = 0;

  task automatic cyc(input bit fs, input int unsigned va_pct, input int unsigned wr_pct);
    @(posedge clock); #1;
    if (wr_req && ack_s) begin
      wr_req = 1'b0;
      hold   = 0;
    end
    if (wr_req) begin
      hold++;
      if (hold > 600) begin
        chk("host_wait_bound", 32'(hold), 32'd600);
        wr_req = 1'b0;
        hold   = 0;
        if (wr_q.size() > 0) void'(wr_q.pop_back());
      end
    end else if ($urandom_range(99) < wr_pct) begin
      wr_req  = 1'b1;
      wr_addr = AW'(PIX + $urandom_range(0, 4095));
      wr_data = DW'($urandom);
      wr_q.push_back(wr_t'{a: wr_addr, d: wr_data});
    end
    frame_start = fs;
    vid_active  = !fs && !fs_prev && ($urandom_range(99) < va_pct);
    fs_prev     = fs;
  endtask

  task automatic run(input int n, input int unsigned va_pct, input int unsigned wr_pct);
    for (int i = 0; i < n; i++) cyc(1'b0, va_pct, wr_pct);
  endtask

  task automatic drain_host(input int unsigned va_pct);
    for (int i = 0; i < 800 && wr_req; i++) cyc(1'b0, va_pct, 0);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; vid_active = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    run(12, 0, 100);                 // host owns the RAM before the first frame
    drain_host(0);

    cyc(1'b1, 0, 0); run(24, 0, 0);  // prefetch 0..15 then idle with FIFO full
    run(40, 50, 60);                 // host competes with a part-full FIFO
    run(300, 70, 40);                // runs past end of frame into underflow

    cyc(1'b1, 0, 0); run(200, 60, 50);
    drain_host(60);

    cyc(1'b1, 0, 0); run(8, 100, 0); // frame_start with a read in flight
    cyc(1'b1, 0, 0); run(150, 80, 30);
    drain_host(0);

    cyc(1'b1, 0, 0); run(10, 0, 0);  // FIFO about half full
    @(posedge clock); #3;
    vid_active = 1'b1; reset = 1'b1; // asynchronous reset mid-cycle
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; vid_active = 1'b0; fs_prev = 0;

    run(6, 0, 100);                  // back in WAIT_FRAME
    drain_host(0);
    run(1, 100, 0);                  // empty FIFO -> underflow
    run(2, 0, 0);
    cyc(1'b1, 0, 0); run(PIX + 60, 100, 0);
    cyc(1'b1, 0, 0); run(60, 40, 80);
    drain_host(0);
    run(2, 0, 0);

    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
